ibuf_queue: RTL and testbench
=============================

Name: ibuf_queue

Overview:
Parametrised instruction prefetch queue, the next-generation replacement for the fixed 16x16 prefetch RAM with its aligned 32-bit read port.
- Fetch/BIU side pushes bus words through a valid/ready handshake.
- Decoder side sees an unaligned, byte-granular window plus an available-byte count, and consumes 0..WIN_BYTES bytes per cycle.
- A flush with start-offset supports jumps to addresses not aligned to a word boundary.

Parameters:
WORD_BYTES, 2, bytes per pushed bus word (power of 2, >=1)
DEPTH_WORDS, 8, queue capacity in words (power of 2, >=2)
WIN_BYTES, 4, decoder window width in bytes (<= WORD_BYTES*DEPTH_WORDS)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
push_valid  in  1  fetch word offered
push_ready  out  1  queue can accept one word this cycle
push_data  in  WORD_BYTES*8  fetched word, byte 0 in bits [7:0] = lowest address
flush  in  1  discard all contents (jump/interrupt)
flush_ofs  in  clog2(WORD_BYTES) (min 1)  byte offset of the target address within the first word pushed after flush
win_data  out  WIN_BYTES*8  bytes at read pointer, byte 0 in bits [7:0]
win_avail  out  clog2(WIN_BYTES+1)  valid bytes in win_data = min(count, WIN_BYTES)
consume  in  clog2(WIN_BYTES+1)  bytes retired by the decoder this cycle
count  out  clog2(WORD_BYTES*DEPTH_WORDS+1)  bytes held
overrun_err  out  1  sticky: consume exceeded win_avail

Behaviour:
- Storage: DEPTH_WORDS x WORD_BYTES byte array in flops. wr_ptr is a word index; rd_ptr is a byte index, both wrapping modulo capacity. count is in bytes; skip holds 0..WORD_BYTES-1 bytes.
- Reset (async, rst_n=0): wr_ptr=0, rd_ptr=0, count=0, skip=0, overrun_err=0. Outputs during reset: push_ready=1, win_avail=0, win_data=0, count=0.
- push_ready = (capacity - count - skip_pending) >= WORD_BYTES. Combinational from registers only, never from push_valid.
- Push accepted when push_valid & push_ready. The word is written at wr_ptr and wr_ptr increments.
  - Normally count += WORD_BYTES.
  - On the first push after a flush: count += WORD_BYTES - skip, rd_ptr already points at byte skip; skip then clears.
- Pushed bytes appear in win_data/win_avail the cycle after acceptance. There is no same-cycle bypass.
- win_data byte i = storage[(rd_ptr+i) mod capacity] for i < win_avail, else 0. Reads wrap across the last and first words.
- Consume: effective c = min(consume, win_avail). rd_ptr += c, count -= c.
  - If consume > win_avail, set overrun_err (sticky until reset).
- Push and consume in the same cycle: count' = count + pushed - c. Both apply.
- Flush has priority over push and consume in the same cycle. The pushed word is dropped (push_ready stays high, so the source must treat it as discarded).
  - Next state: wr_ptr=0, rd_ptr=flush_ofs, count=0, skip=flush_ofs.
  - overrun_err is not cleared by flush.
- Full: count == capacity -> push_ready=0. Consuming in a full cycle frees space visible the next cycle.
- Empty: win_avail=0; consume=0 is legal and causes no error.
- WORD_BYTES=1: flush_ofs is ignored and skip is always 0.
- Reset mid-operation discards everything immediately (asynchronous).

Decomposition:
- Package ibuf_pkg: localparams CAP_BYTES, PTR_W, CNT_W, WIN_CNT_W, and a clog2 helper function.
- One natural sub-module, ibuf_window_mux: combinational rotate/select that builds win_data from storage, rd_ptr and win_avail. All state stays in ibuf_queue.

Test Plan:
- Reset then 4 pushes of 0x1100, 0x3322, 0x5544, 0x7766 with consume=0 -> count=8, win_avail=4, win_data=0x33221100, push_ready=1.
- Then consume=3 every cycle while pushing 0x9988 -> windows 0x33221100, 0x66554433, 0x99887766 in sequence; count tracks 8 + 2 per push - 3 per consume.
- Fill to 16 bytes -> push_ready=0; a push_valid held high is not accepted. consume=2 -> push_ready=1 next cycle. Continue through wrap: window spans word 7 to word 0 correctly.
- flush=1 with flush_ofs=1 and a simultaneous push -> the push is dropped. Next push 0xBBAA -> count=1, win_avail=1, win_data=0x000000BB.
- count=2, consume=4 -> count=0, rd_ptr advances 2, overrun_err=1 and stays 1 after a subsequent flush.
- Assert rst_n low mid-stream with count=6 -> outputs immediately go to reset values; after release, the first push shows win_avail=2.

Source files
------------

// File: rtl/ibuf_pkg.sv
// Shared sizing helpers and default geometry for the instruction prefetch queue.
package ibuf_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  localparam int WORD_BYTES_DEF  = 2;
  localparam int DEPTH_WORDS_DEF = 8;
  localparam int WIN_BYTES_DEF   = 4;

  localparam int CAP_BYTES = WORD_BYTES_DEF * DEPTH_WORDS_DEF;
  localparam int PTR_W     = clog2(CAP_BYTES);
  localparam int CNT_W     = clog2(CAP_BYTES + 1);
  localparam int WIN_CNT_W = clog2(WIN_BYTES_DEF + 1);

endpackage

// File: rtl/ibuf_window_mux.sv
// Builds the decoder window: WIN_BYTES bytes starting at the byte read pointer,
// wrapping around the byte ring, with bytes beyond win_avail forced to zero.
module ibuf_window_mux
  import ibuf_pkg::*;
#(
  parameter int CAP_BYTES_P = CAP_BYTES,
  parameter int WIN_BYTES_P = WIN_BYTES_DEF,
  parameter int PTR_W_P     = PTR_W,
  parameter int WIN_CNT_W_P = WIN_CNT_W
) (
  input  logic [CAP_BYTES_P*8-1:0] store_i,
  input  logic [PTR_W_P-1:0]       rd_ptr_i,
  input  logic [WIN_CNT_W_P-1:0]   win_avail_i,
  output logic [WIN_BYTES_P*8-1:0] win_data_o
);

  logic [PTR_W_P-1:0] idx;

  always_comb begin
    win_data_o = '0;
    idx        = '0;
    for (int i = 0; i < WIN_BYTES_P; i++) begin
      // Ring capacity is a power of two, so truncation gives the wrap.
      idx = rd_ptr_i + PTR_W_P'(i);
      if (WIN_CNT_W_P'(i) < win_avail_i) begin
        win_data_o[i*8 +: 8] = store_i[{idx, 3'b000} +: 8];
      end
    end
  end

endmodule

// File: rtl/ibuf_queue.sv
// Instruction prefetch queue: word-wide push from the bus interface, byte-granular
// unaligned window and variable consume toward the decoder, flush with start offset.
module ibuf_queue
  import ibuf_pkg::*;
#(
  parameter int WORD_BYTES  = WORD_BYTES_DEF,
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int WIN_BYTES   = WIN_BYTES_DEF,
  localparam int Q_CAP   = WORD_BYTES * DEPTH_WORDS,
  localparam int Q_PTR_W = clog2(Q_CAP),
  localparam int Q_CNT_W = clog2(Q_CAP + 1),
  localparam int Q_WIN_W = clog2(WIN_BYTES + 1),
  localparam int Q_OFS_W = max1(clog2(WORD_BYTES)),
  localparam int Q_WP_W  = clog2(DEPTH_WORDS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_valid,
  output logic                    push_ready,
  input  logic [WORD_BYTES*8-1:0] push_data,
  input  logic                    flush,
  input  logic [Q_OFS_W-1:0]      flush_ofs,
  output logic [WIN_BYTES*8-1:0]  win_data,
  output logic [Q_WIN_W-1:0]      win_avail,
  input  logic [Q_WIN_W-1:0]      consume,
  output logic [Q_CNT_W-1:0]      count,
  output logic                    overrun_err
);

  logic [WORD_BYTES*8-1:0] mem_q [DEPTH_WORDS];
  logic [Q_CAP*8-1:0]      store_flat;

  logic [Q_WP_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [Q_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [Q_CNT_W-1:0] count_q, count_d;
  logic [Q_OFS_W-1:0] skip_q, skip_d;
  logic               overrun_q, overrun_d;

  logic [Q_CNT_W-1:0] free_bytes;
  logic [Q_WIN_W-1:0] consume_eff;
  logic [Q_OFS_W-1:0] ofs_eff;
  logic               push_acc;
  logic               overrun_set;

  // Single-byte words cannot be entered mid-word, so the offset is meaningless.
  assign ofs_eff = (WORD_BYTES == 1) ? '0 : flush_ofs;

  // Skipped bytes of the pending first word still need room in the ring.
  assign free_bytes = Q_CNT_W'(Q_CAP) - count_q - Q_CNT_W'(skip_q);
  assign push_ready = (free_bytes >= Q_CNT_W'(WORD_BYTES));
  assign push_acc   = push_valid & push_ready & ~flush;

  assign win_avail   = (count_q > Q_CNT_W'(WIN_BYTES)) ? Q_WIN_W'(WIN_BYTES) : Q_WIN_W'(count_q);
  assign overrun_set = (consume > win_avail);
  assign consume_eff = overrun_set ? win_avail : consume;

  assign count       = count_q;
  assign overrun_err = overrun_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    skip_d    = skip_q;
    overrun_d = overrun_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = Q_PTR_W'(ofs_eff);
      count_d  = '0;
      skip_d   = ofs_eff;
    end else begin
      rd_ptr_d = rd_ptr_q + Q_PTR_W'(consume_eff);
      count_d  = count_q - Q_CNT_W'(consume_eff);
      if (overrun_set) overrun_d = 1'b1;
      if (push_acc) begin
        wr_ptr_d = wr_ptr_q + Q_WP_W'(1);
        count_d  = count_d + Q_CNT_W'(WORD_BYTES) - Q_CNT_W'(skip_q);
        skip_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      skip_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      skip_q    <= skip_d;
      overrun_q <= overrun_d;
    end
  end

  // Payload needs no reset: the window masks every byte outside count.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= push_data;
  end

  for (genvar g = 0; g < DEPTH_WORDS; g++) begin : g_flat
    assign store_flat[g*WORD_BYTES*8 +: WORD_BYTES*8] = mem_q[g];
  end

  ibuf_window_mux #(
    .CAP_BYTES_P (Q_CAP),
    .WIN_BYTES_P (WIN_BYTES),
    .PTR_W_P     (Q_PTR_W),
    .WIN_CNT_W_P (Q_WIN_W)
  ) u_win_mux (
    .store_i     (store_flat),
    .rd_ptr_i    (rd_ptr_q),
    .win_avail_i (win_avail),
    .win_data_o  (win_data)
  );

endmodule

// File: tb/tb_ibuf_queue.sv
// Directed bench for ibuf_queue at default geometry (2-byte words, 8 deep, 4-byte window).
module tb_ibuf_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        push_valid = 1'b0;
  logic        push_ready;
  logic [15:0] push_data = '0;
  logic        flush = 1'b0;
  logic [0:0]  flush_ofs = '0;
  logic [31:0] win_data;
  logic [2:0]  win_avail;
  logic [2:0]  consume = '0;
  logic [4:0]  count;
  logic        overrun_err;

  int vectors = 0;
  int miscompares = 0;

  ibuf_queue #(
    .WORD_BYTES  (2),
    .DEPTH_WORDS (8),
    .WIN_BYTES   (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_valid  (push_valid),
    .push_ready  (push_ready),
    .push_data   (push_data),
    .flush       (flush),
    .flush_ofs   (flush_ofs),
    .win_data    (win_data),
    .win_avail   (win_avail),
    .consume     (consume),
    .count       (count),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] d);
    push_valid = 1'b1;
    push_data  = d;
    tick();
    push_valid = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_ready", 32'(push_ready), 32'd1);
    chk("rst_avail", 32'(win_avail), 32'd0);
    chk("rst_data", win_data, 32'h0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovr", 32'(overrun_err), 32'd0);
    #1 rst_n = 1'b1;

    // four pushes, no consume
    push(16'h1100);
    push(16'h3322);
    push(16'h5544);
    push(16'h7766);
    chk("fill4_count", 32'(count), 32'd8);
    chk("fill4_avail", 32'(win_avail), 32'd4);
    chk("fill4_data", win_data, 32'h33221100);
    chk("fill4_ready", 32'(push_ready), 32'd1);

    // consume 3 per cycle while pushing
    push_valid = 1'b1;
    push_data  = 16'h9988;
    consume    = 3'd3;
    tick();
    chk("c3a_data", win_data, 32'h66554433);
    chk("c3a_count", 32'(count), 32'd7);
    tick();
    chk("c3b_data", win_data, 32'h99887766);
    chk("c3b_count", 32'(count), 32'd6);
    push_valid = 1'b0;
    consume    = 3'd0;

    // fill to capacity
    push(16'hA1A0);
    push(16'hA3A2);
    push(16'hA5A4);
    push(16'hA7A6);
    push(16'hA9A8);
    chk("full_ready", 32'(push_ready), 32'd0);
    chk("full_count", 32'(count), 32'd16);
    push_valid = 1'b1;
    push_data  = 16'hEEEE;
    tick();
    chk("full_hold_count", 32'(count), 32'd16);
    chk("full_hold_data", win_data, 32'h99887766);
    consume = 3'd2;
    tick();
    chk("free_ready", 32'(push_ready), 32'd1);
    chk("free_count", 32'(count), 32'd14);
    chk("free_data", win_data, 32'h99889988);
    push_valid = 1'b0;
    consume    = 3'd4;
    tick();
    chk("c4_data", win_data, 32'hA3A2A1A0);
    chk("c4_count", 32'(count), 32'd10);
    consume = 3'd2;
    tick();
    chk("wrap_data", win_data, 32'hA5A4A3A2);
    chk("wrap_count", 32'(count), 32'd8);
    consume = 3'd0;

    // flush with offset, simultaneous push dropped
    flush      = 1'b1;
    flush_ofs  = 1'b1;
    push_valid = 1'b1;
    push_data  = 16'hDEAD;
    tick();
    flush      = 1'b0;
    push_valid = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_avail", 32'(win_avail), 32'd0);
    chk("flush_ready", 32'(push_ready), 32'd1);
    push(16'hBBAA);
    chk("ofs_count", 32'(count), 32'd1);
    chk("ofs_avail", 32'(win_avail), 32'd1);
    chk("ofs_data", win_data, 32'h000000BB);

    // over-consume
    push(16'hDDCC);
    consume = 3'd1;
    tick();
    consume = 3'd0;
    chk("pre_ovr_avail", 32'(win_avail), 32'd2);
    chk("pre_ovr_data", win_data, 32'h0000DDCC);
    chk("pre_ovr_flag", 32'(overrun_err), 32'd0);
    consume = 3'd4;
    tick();
    consume = 3'd0;
    chk("ovr_count", 32'(count), 32'd0);
    chk("ovr_flag", 32'(overrun_err), 32'd1);
    chk("ovr_avail", 32'(win_avail), 32'd0);
    push(16'hFFEE);
    chk("ovr_rdptr_data", win_data, 32'h0000FFEE);
    chk("ovr_rdptr_count", 32'(count), 32'd2);
    flush     = 1'b1;
    flush_ofs = 1'b0;
    tick();
    flush = 1'b0;
    chk("ovr_sticky", 32'(overrun_err), 32'd1);
    chk("flush2_count", 32'(count), 32'd0);

    // asynchronous reset mid-stream
    push(16'h0201);
    push(16'h0403);
    push(16'h0605);
    chk("pre_rst_count", 32'(count), 32'd6);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_avail", 32'(win_avail), 32'd0);
    chk("arst_data", win_data, 32'h0);
    chk("arst_ready", 32'(push_ready), 32'd1);
    chk("arst_ovr", 32'(overrun_err), 32'd0);
    #1 rst_n = 1'b1;
    push(16'h0807);
    chk("post_rst_avail", 32'(win_avail), 32'd2);
    chk("post_rst_data", win_data, 32'h00000807);
    chk("post_rst_count", 32'(count), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
